// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default datapath width, primary opcodes,
// fetch-stage state encoding and the IF/ID pipeline register layout.
package mips_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [5:0] OPC_NOP   = 6'h3F;
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD
  } fetch_state_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues one outstanding word fetch at a time over a req/ack handshake,
// buffers an instruction acked during a stall in a skid register, and
// honours branch redirect/flush with priority over stall.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_rdata/imem_ack : instruction memory handshake
//   stall_in                              : hold PC and IF/ID
//   branch_taken/branch_target            : redirect + flush pulse
//   if_id_valid/if_id_instr/if_id_pc4     : IF/ID register to decode
//   next_opCode                           : opcode to main control (NOP on bubble)
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  input  logic            stall_in,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [5:0]      next_opCode
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_addr, req_addr_n;
  logic [XLEN-1:0] skid, skid_n;
  logic            drop, drop_n;
  logic            valid_n;
  logic [XLEN-1:0] instr_n, pc4_n;
  logic [XLEN-1:0] req_addr_inc;
  logic [XLEN-1:0] redirect;

  assign req_addr_inc = req_addr + XLEN'(4);
  assign redirect     = branch_taken ? branch_target : pc;

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = req_addr;
  assign next_opCode = if_id_valid ? if_id_instr[XLEN-1:XLEN-6] : OPC_NOP;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    skid_n     = skid;
    drop_n     = drop;
    valid_n    = if_id_valid;
    instr_n    = if_id_instr;
    pc4_n      = if_id_pc4;
    unique case (state)
      S_BOOT: begin
        req_addr_n = pc;
        state_n    = S_REQ;
      end
      S_REQ: begin
        if (imem_ack && (drop || branch_taken)) begin
          // Stale or redirected response: restart fetch at the redirect point.
          pc_n       = redirect;
          req_addr_n = redirect;
          drop_n     = 1'b0;
          valid_n    = 1'b0;
        end else if (branch_taken) begin
          // Cannot abandon the in-flight request; mark its data for discard.
          pc_n    = branch_target;
          drop_n  = 1'b1;
          valid_n = 1'b0;
        end else if (imem_ack && !stall_in) begin
          valid_n    = 1'b1;
          instr_n    = imem_rdata;
          pc4_n      = req_addr_inc;
          pc_n       = req_addr_inc;
          req_addr_n = req_addr_inc;
        end else if (imem_ack) begin
          skid_n  = imem_rdata;
          pc_n    = req_addr_inc;
          state_n = S_HOLD;
        end else if (!stall_in) begin
          valid_n = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_n       = branch_target;
          req_addr_n = branch_target;
          valid_n    = 1'b0;
          state_n    = S_REQ;
        end else if (!stall_in) begin
          // pc already holds the skid instruction's PC+4.
          valid_n    = 1'b1;
          instr_n    = skid;
          pc4_n      = pc;
          req_addr_n = pc;
          state_n    = S_REQ;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      skid        <= '0;
      drop        <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_addr    <= req_addr_n;
      skid        <= skid_n;
      drop        <= drop_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
    end
  end

endmodule
